// File: rtl/paddle_if.sv
// Frame-tick, button and paddle-position bundle between the
// game front end and the paddle controller.
interface paddle_if #(
  parameter int Y_WIDTH = 10
);
  logic               frame_tick;
  logic [3:0]         btn;
  logic [Y_WIDTH-1:0] p1_y;
  logic [Y_WIDTH-1:0] p2_y;
  logic               p1_moving;
  logic               p2_moving;

  modport master (
    output frame_tick,
    output btn,
    input  p1_y,
    input  p2_y,
    input  p1_moving,
    input  p2_moving
  );

  modport slave (
    input  frame_tick,
    input  btn,
    output p1_y,
    output p2_y,
    output p1_moving,
    output p2_moving
  );
endinterface

// File: rtl/paddle_controller.sv
// Two independent per-frame paddle channels with hold-to-accelerate
// and playfield clamping.
module paddle_channel #(
  parameter int SCREEN_HEIGHT = 480,
  parameter int PADDLE_HEIGHT = 80,
  parameter int BASE_SPEED    = 2,
  parameter int MAX_SPEED     = 8,
  parameter int ACCEL_FRAMES  = 8,
  parameter int Y_WIDTH       = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               up,
  input  logic               dn,
  output logic [Y_WIDTH-1:0] y,
  output logic               moving
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  localparam int YW = Y_WIDTH;
  localparam logic [3:0]  BASE4 = 4'(BASE_SPEED);
  localparam logic [3:0]  MAX4  = 4'(MAX_SPEED);
  localparam logic [4:0]  MAX5  = 5'(MAX_SPEED);
  localparam logic [7:0]  ACC8  = 8'(ACCEL_FRAMES);
  localparam logic [YW-1:0] YMAX_N =
    YW'(SCREEN_HEIGHT - PADDLE_HEIGHT);
  localparam logic [YW:0] YMAX_W =
    (YW+1)'(SCREEN_HEIGHT - PADDLE_HEIGHT);
  localparam logic [YW-1:0] YCTR =
    YW'((SCREEN_HEIGHT - PADDLE_HEIGHT) / 2);

  state_t        state_q, state_d, req;
  logic [3:0]    speed_q, speed_d, step;
  logic [7:0]    hold_q, hold_d, hold_inc;
  logic [4:0]    spd_up;
  logic [YW-1:0] y_q, y_d, step_n;
  logic [YW:0]   sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      speed_q <= BASE4;
      hold_q  <= '0;
      y_q     <= YCTR;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      hold_q  <= hold_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    speed_d  = speed_q;
    hold_d   = hold_q;
    y_d      = y_q;
    unique case ({up, dn})
      2'b10:   req = UP;
      2'b01:   req = DOWN;
      default: req = IDLE;
    endcase
    // entry or reversal restarts the profile at base speed
    step     = speed_q;
    hold_inc = hold_q + 8'd1;
    if (state_q != req) begin
      step     = BASE4;
      hold_inc = 8'd1;
    end
    spd_up = {1'b0, step} + 5'd1;
    step_n = {{(YW-4){1'b0}}, step};
    sum    = {1'b0, y_q} + {{(YW-3){1'b0}}, step};
    if (tick) begin
      if (req == IDLE) begin
        state_d = IDLE;
        speed_d = BASE4;
        hold_d  = '0;
      end else begin
        state_d = req;
        if (hold_inc == ACC8) begin
          hold_d  = '0;
          speed_d = (spd_up > MAX5) ? MAX4 : spd_up[3:0];
        end else begin
          hold_d  = hold_inc;
          speed_d = step;
        end
        if (req == UP)
          y_d = (y_q < step_n) ? '0 : y_q - step_n;
        else
          y_d = (sum > YMAX_W) ? YMAX_N : sum[YW-1:0];
      end
    end
  end

  assign y      = y_q;
  assign moving = (state_q != IDLE);
endmodule

module paddle_controller #(
  parameter int SCREEN_HEIGHT = 480,
  parameter int PADDLE_HEIGHT = 80,
  parameter int BASE_SPEED    = 2,
  parameter int MAX_SPEED     = 8,
  parameter int ACCEL_FRAMES  = 8,
  parameter int Y_WIDTH       = 10
) (
  input logic     clk,
  input logic     rst,
  paddle_if.slave bus
);
  logic [Y_WIDTH-1:0] y1, y2;
  logic               m1, m2;

  paddle_channel #(
    .SCREEN_HEIGHT(SCREEN_HEIGHT),
    .PADDLE_HEIGHT(PADDLE_HEIGHT),
    .BASE_SPEED   (BASE_SPEED),
    .MAX_SPEED    (MAX_SPEED),
    .ACCEL_FRAMES (ACCEL_FRAMES),
    .Y_WIDTH      (Y_WIDTH)
  ) u_p1 (
    .clk   (clk),
    .rst   (rst),
    .tick  (bus.frame_tick),
    .up    (bus.btn[0]),
    .dn    (bus.btn[1]),
    .y     (y1),
    .moving(m1)
  );

  paddle_channel #(
    .SCREEN_HEIGHT(SCREEN_HEIGHT),
    .PADDLE_HEIGHT(PADDLE_HEIGHT),
    .BASE_SPEED   (BASE_SPEED),
    .MAX_SPEED    (MAX_SPEED),
    .ACCEL_FRAMES (ACCEL_FRAMES),
    .Y_WIDTH      (Y_WIDTH)
  ) u_p2 (
    .clk   (clk),
    .rst   (rst),
    .tick  (bus.frame_tick),
    .up    (bus.btn[2]),
    .dn    (bus.btn[3]),
    .y     (y2),
    .moving(m2)
  );

  assign bus.p1_y      = y1;
  assign bus.p2_y      = y2;
  assign bus.p1_moving = m1;
  assign bus.p2_moving = m2;
endmodule
